// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the execute-stage ALU with iterative mult/div.
package alu_muldiv_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int MD_ITER_DEF = 32;

  // Operation codes delivered by the ALU control decoder.
  localparam logic [4:0] OP_PASSB = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_NOR   = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SR    = 5'd8;
  localparam logic [4:0] OP_SLT   = 5'd9;
  localparam logic [4:0] OP_MULT  = 5'd10;
  localparam logic [4:0] OP_DIV   = 5'd11;
  localparam logic [4:0] OP_MFHI  = 5'd12;
  localparam logic [4:0] OP_MFLO  = 5'd13;
  localparam logic [4:0] OP_MTHI  = 5'd14;
  localparam logic [4:0] OP_MTLO  = 5'd15;

  typedef enum logic {IDLE, RUN} md_state_t;

  // Ops that touch the mult/div unit or HI/LO and therefore must wait while it is busy.
  function automatic logic is_md_op(logic [4:0] op);
    return (op >= OP_MULT) && (op <= OP_MTLO);
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Instruction-side bundle between the decode/control stage and the execute datapath.
interface alu_muldiv_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        ALUCtrl;
  logic              Sign;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] Result;
  logic              Zero;
  logic              Stall;
  logic              Busy;

  modport master (output ALUCtrl, Sign, A, B, input Result, Zero, Stall, Busy);
  modport slave  (input ALUCtrl, Sign, A, B, output Result, Zero, Stall, Busy);
endinterface

// File: rtl/alu_muldiv_muldiv_iter.sv
// Iterative 1-bit-per-cycle multiplier / restoring divider on operand magnitudes,
// with sign fix-up applied to the final step so HI/LO can be written on the last edge.
module alu_muldiv_muldiv_iter
  import alu_muldiv_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MD_ITER = MD_ITER_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_div,
  input  logic              sign,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_res,
  output logic [DATA_W-1:0] lo_res
);

  localparam int CNT_W = $clog2(MD_ITER);
  localparam int W2    = 2 * DATA_W;

  md_state_t         state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              op_div;
  logic              neg_main;   // product / quotient sign differs from magnitude result
  logic              neg_rem;    // remainder takes the dividend's sign
  logic [DATA_W-1:0] opnd;       // multiplicand or divisor magnitude
  logic [W2-1:0]     acc;        // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [W2-1:0]     acc_step;
  logic [W2-1:0]     prod_fix;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] addend;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W-1:0] quo, rem;
  logic              last;

  assign a_mag = (sign && a[DATA_W-1]) ? -a : a;
  assign b_mag = (sign && b[DATA_W-1]) ? -b : b;

  assign busy = (state == RUN);
  assign last = (state == RUN) && (cnt == CNT_W'(MD_ITER - 1));
  assign done = last;

  // State register for the IDLE/RUN sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state: leave IDLE on issue, return after the final iteration.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One shift-add (mult) or one restoring-subtract (div) iteration.
  always_comb begin
    acc_step = acc;
    addend   = acc[0] ? opnd : '0;
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    if (!op_div) begin
      sum      = {1'b0, acc[W2-1:DATA_W]} + {1'b0, addend};
      acc_step = {sum, acc[DATA_W-1:1]};
    end else begin
      rem_sh = {acc[W2-1:DATA_W], acc[DATA_W-1]};
      diff   = rem_sh - {1'b0, opnd};
      if (!diff[DATA_W]) acc_step = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      else               acc_step = {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    end
  end

  // Sign fix-up of the completed magnitude result; divide-by-zero forces an all-ones quotient.
  always_comb begin
    prod_fix = neg_main ? -acc_step : acc_step;
    quo      = acc_step[DATA_W-1:0];
    rem      = acc_step[W2-1:DATA_W];
    if (!op_div) begin
      hi_res = prod_fix[W2-1:DATA_W];
      lo_res = prod_fix[DATA_W-1:0];
    end else begin
      hi_res = neg_rem ? -rem : rem;
      if (opnd == '0) lo_res = '1;
      else            lo_res = neg_main ? -quo : quo;
    end
  end

  // Operand capture on issue, iteration while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        cnt      <= '0;
        op_div   <= is_div;
        neg_main <= sign && (a[DATA_W-1] ^ b[DATA_W-1]);
        neg_rem  <= sign && a[DATA_W-1];
        if (is_div) begin
          opnd <= b_mag;
          acc  <= {{DATA_W{1'b0}}, a_mag};
        end else begin
          opnd <= a_mag;
          acc  <= {{DATA_W{1'b0}}, b_mag};
        end
      end
    end else begin
      acc <= acc_step;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle ops 0-9 plus HI/LO access and an iterative mult/div unit.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MD_ITER = MD_ITER_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  alu_muldiv_if.slave  bus
);

  logic [DATA_W-1:0] hi, lo;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] md_hi, md_lo;
  logic [4:0]        shamt;
  logic              lt;
  logic              busy, stall, start, md_done;

  assign shamt = bus.A[4:0];
  assign stall = busy && is_md_op(bus.ALUCtrl);
  assign start = ((bus.ALUCtrl == OP_MULT) || (bus.ALUCtrl == OP_DIV)) && !busy;

  alu_muldiv_muldiv_iter #(
    .DATA_W  (DATA_W),
    .MD_ITER (MD_ITER)
  ) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .is_div  (bus.ALUCtrl == OP_DIV),
    .sign    (bus.Sign),
    .a       (bus.A),
    .b       (bus.B),
    .busy    (busy),
    .done    (md_done),
    .hi_res  (md_hi),
    .lo_res  (md_lo)
  );

  // Combinational result; HI/LO reads are suppressed while the instruction is stalled.
  always_comb begin
    alu_res = '0;
    lt      = 1'b0;
    case (bus.ALUCtrl)
      OP_PASSB: alu_res = bus.B;
      OP_ADD:   alu_res = bus.A + bus.B;
      OP_SUB:   alu_res = bus.A - bus.B;
      OP_AND:   alu_res = bus.A & bus.B;
      OP_OR:    alu_res = bus.A | bus.B;
      OP_XOR:   alu_res = bus.A ^ bus.B;
      OP_NOR:   alu_res = ~(bus.A | bus.B);
      OP_SLL:   alu_res = bus.B << shamt;
      OP_SR:    alu_res = bus.Sign ? $unsigned($signed(bus.B) >>> shamt) : (bus.B >> shamt);
      OP_SLT: begin
        lt      = bus.Sign ? ($signed(bus.A) < $signed(bus.B)) : (bus.A < bus.B);
        alu_res = {{(DATA_W-1){1'b0}}, lt};
      end
      OP_MFHI:  alu_res = stall ? '0 : hi;
      OP_MFLO:  alu_res = stall ? '0 : lo;
      default:  alu_res = '0;
    endcase
  end

  // HI/LO: completion write from the iterative unit, otherwise mthi/mtlo when not stalled.
  // A completion edge always has busy=1, so a concurrent mthi/mtlo is stalled and cannot collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (md_done) begin
      hi <= md_hi;
      lo <= md_lo;
    end else if (!stall) begin
      if (bus.ALUCtrl == OP_MTHI) hi <= bus.A;
      if (bus.ALUCtrl == OP_MTLO) lo <= bus.A;
    end
  end

  assign bus.Result = alu_res;
  assign bus.Zero   = (alu_res == '0);
  assign bus.Stall  = stall;
  assign bus.Busy   = busy;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: the driver pushes expected retirements, a monitor checks them.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_if #(.DATA_W(32)) bus ();

  alu_muldiv #(.DATA_W(32), .MD_ITER(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    int          stall;
    bit          busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   hold = 1'b1;

  // Architectural reference model: HI/LO, pending completion and remaining busy cycles.
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_busy = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
    longint sb_l;
    case (op)
      5'd0:  return b;
      5'd1:  return a + b;
      5'd2:  return a - b;
      5'd3:  return a & b;
      5'd4:  return a | b;
      5'd5:  return a ^ b;
      5'd6:  return ~(a | b);
      5'd7:  return b << a[4:0];
      5'd8: begin
        if (!sgn) return b >> a[4:0];
        sb_l = longint'($signed(b));
        sb_l = sb_l / (longint'(1) << a[4:0]) - ((sb_l < 0 && (sb_l % (longint'(1) << a[4:0])) != 0) ? 1 : 0);
        return sb_l[31:0];
      end
      5'd9:  return sgn ? {31'b0, $signed(a) < $signed(b)} : {31'b0, a < b};
      5'd12: return hi;
      5'd13: return lo;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void ref_md(input logic [4:0] op, input bit sgn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sbv, q, r;
    logic [63:0] p;
    if (op == OP_MULT) begin
      if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else     p = {32'b0, a} * {32'b0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'h0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (sgn) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      q   = sa / sbv;
      r   = sa % sbv;
      lo  = q[31:0];
      hi  = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  task automatic tick();
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end
  endtask

  // Present one instruction, predict its retirement, hold it while stalled, then commit.
  task automatic exec(input logic [4:0] op, input bit sgn, input logic [31:0] a,
                      input logic [31:0] b, input string name);
    exp_t e;
    int   n;
    bus.ALUCtrl = op;
    bus.Sign    = sgn;
    bus.A       = a;
    bus.B       = b;
    e.name  = name;
    e.stall = is_md_op(op) ? m_busy : 0;
    repeat (e.stall) tick();
    e.busy = (m_busy > 0);
    e.res  = ref_alu(op, sgn, a, b, m_hi, m_lo);
    sb.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.Stall) break;
      n++;
      if (n > 64) begin
        checks++;
        errors++;
        $display("FAIL %s_stall_timeout: got >%0d stall cycles, expected %0d", name, n - 1, e.stall);
        break;
      end
    end
    @(posedge clk);
    tick();
    if (op == OP_MULT || op == OP_DIV) begin
      ref_md(op, sgn, a, b, m_phi, m_plo);
      m_busy = 32;
    end else if (op == OP_MTHI) begin
      m_hi = a;
    end else if (op == OP_MTLO) begin
      m_lo = a;
    end
    #1;
  endtask

  // Monitor: every unstalled cycle retires the oldest outstanding instruction.
  initial begin
    exp_t e;
    int   stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (hold || !reset_n) begin
        stall_cnt = 0;
      end else if (bus.Stall) begin
        stall_cnt++;
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        check32({e.name, "_result"}, bus.Result, e.res);
        check32({e.name, "_zero"}, {31'b0, bus.Zero}, {31'b0, e.res == 32'h0});
        check32({e.name, "_stall_cycles"}, 32'(stall_cnt), 32'(e.stall));
        check32({e.name, "_busy"}, {31'b0, bus.Busy}, {31'b0, e.busy});
        $display("txn %-22s op=%0d A=%h B=%h S=%0d -> Result=%h stall=%0d busy=%0d",
                 e.name, bus.ALUCtrl, bus.A, bus.B, bus.Sign, bus.Result, stall_cnt, bus.Busy);
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    int          r;
    bit          sgn;

    bus.ALUCtrl = OP_MFLO;
    bus.Sign    = 1'b0;
    bus.A       = 32'h0;
    bus.B       = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_busy", {31'b0, bus.Busy}, 32'h0);
    check32("reset_stall", {31'b0, bus.Stall}, 32'h0);
    check32("reset_lo", bus.Result, 32'h0);
    bus.ALUCtrl = OP_PASSB;
    bus.B       = 32'hABCD_1234;
    #1;
    check32("reset_comb_passb", bus.Result, 32'hABCD_1234);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    hold = 1'b0;

    // Combinational boundary cases.
    exec(OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'h1, "slt_signed");
    exec(OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'h1, "slt_unsigned");
    exec(OP_SR,  1'b1, 32'h4, 32'h8000_0000, "sra");
    exec(OP_SR,  1'b0, 32'h4, 32'h8000_0000, "srl");
    exec(OP_SUB, 1'b0, 32'h5, 32'h5, "sub_zero");
    exec(OP_NOR, 1'b0, 32'h0F0F_0000, 32'h0000_F0F0, "nor");
    exec(OP_SLL, 1'b0, 32'd31, 32'h3, "sll");

    // Signed mult with dependent mflo, then unsigned max mult.
    exec(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7, "mult_s_neg3x7");
    exec(OP_MFLO, 1'b0, 32'h0, 32'h0, "mflo_after_mult");
    exec(OP_MFHI, 1'b0, 32'h0, 32'h0, "mfhi_after_mult");
    exec(OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_u_max");
    exec(OP_MFHI, 1'b0, 32'h0, 32'h0, "mfhi_u_max");
    exec(OP_MFLO, 1'b0, 32'h0, 32'h0, "mflo_u_max");

    // Divides including divide-by-zero and the signed overflow corner.
    exec(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, "div_s_neg7_2");
    exec(OP_MFLO, 1'b0, 32'h0, 32'h0, "mflo_div_s");
    exec(OP_MFHI, 1'b0, 32'h0, 32'h0, "mfhi_div_s");
    exec(OP_DIV, 1'b0, 32'd9, 32'h0, "div_by_zero");
    exec(OP_MFLO, 1'b0, 32'h0, 32'h0, "mflo_div0");
    exec(OP_MFHI, 1'b0, 32'h0, 32'h0, "mfhi_div0");
    exec(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_s_ovf");
    exec(OP_MFLO, 1'b0, 32'h0, 32'h0, "mflo_div_ovf");
    exec(OP_MFHI, 1'b0, 32'h0, 32'h0, "mfhi_div_ovf");

    // Independent op during RUN, then mthi stalls until after completion.
    exec(OP_MULT, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, "mult_bg");
    exec(OP_ADD, 1'b0, 32'd1, 32'd2, "add_during_run");
    exec(OP_MTHI, 1'b0, 32'h55, 32'h0, "mthi_during_run");
    exec(OP_MFHI, 1'b0, 32'h0, 32'h0, "mfhi_after_mthi");
    exec(OP_MFLO, 1'b0, 32'h0, 32'h0, "mflo_after_mthi");

    // Asynchronous reset in the middle of a multiply.
    exec(OP_MULT, 1'b0, 32'hDEAD_BEEF, 32'h1357_9BDF, "mult_then_reset");
    for (int i = 0; i < 8; i++) exec(OP_PASSB, 1'b0, 32'h0, 32'(i + 1), "passb_pre_reset");
    hold = 1'b1;
    bus.ALUCtrl = OP_MFLO;
    #2;
    reset_n = 1'b0;
    #1;
    check32("midrun_reset_busy", {31'b0, bus.Busy}, 32'h0);
    check32("midrun_reset_stall", {31'b0, bus.Stall}, 32'h0);
    check32("midrun_reset_lo", bus.Result, 32'h0);
    m_hi = '0; m_lo = '0; m_busy = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    hold = 1'b0;
    exec(OP_MFLO, 1'b0, 32'h0, 32'h0, "mflo_after_reset");
    exec(OP_MFHI, 1'b0, 32'h0, 32'h0, "mfhi_after_reset");

    // Randomised instruction stream.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      op = 5'($urandom_range(10, 11));
      else if (r < 25) op = 5'($urandom_range(12, 15));
      else if (r < 90) op = 5'($urandom_range(0, 9));
      else             op = 5'($urandom_range(16, 31));
      sgn = 1'($urandom_range(0, 1));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      exec(op, sgn, a, b, $sformatf("rnd%0d", i));
    end

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
